// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit: FSM encoding,
// address and counter widths, and the load-use hazard predicate.
package hazard_stall_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FREEZE = 1'b1
    } state_e;

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    function automatic logic detect_load_use(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  uses_rt
    );
        return mem_read && (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: hazard inputs from ID/EX and
// memory, control enables and statistics counters back to the pipeline.
interface hazard_stall_unit_if;
    import hazard_stall_unit_pkg::*;

    logic                  ctrl_mem_read_id_ex;
    logic [REG_ADDR_W-1:0] mux_reg_dst_out_id_ex;
    logic [REG_ADDR_W-1:0] register_RS;
    logic [REG_ADDR_W-1:0] register_RT;
    logic                  ctrl_uses_rt;
    logic                  branch_taken_ex;
    logic                  mem_busy;
    logic                  ctrl_pc_write;
    logic                  ctrl_if_id_write;
    logic                  ctrl_id_ex_bubble;
    logic                  ctrl_if_id_flush;
    logic                  ctrl_pipe_freeze;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output ctrl_mem_read_id_ex, mux_reg_dst_out_id_ex, register_RS, register_RT,
               ctrl_uses_rt, branch_taken_ex, mem_busy,
        input  ctrl_pc_write, ctrl_if_id_write, ctrl_id_ex_bubble, ctrl_if_id_flush,
               ctrl_pipe_freeze, stall_count, flush_count
    );

    modport slave (
        input  ctrl_mem_read_id_ex, mux_reg_dst_out_id_ex, register_RS, register_RT,
               ctrl_uses_rt, branch_taken_ex, mem_busy,
        output ctrl_pc_write, ctrl_if_id_write, ctrl_id_ex_bubble, ctrl_if_id_flush,
               ctrl_pipe_freeze, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at the saturation value.
module sat_counter16
    import hazard_stall_unit_pkg::*;
(
    input  logic             clock,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CNT_SAT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and memory-freeze control for a 5-stage pipeline.
// Priority: reset > mem_busy > flush (pending or live) > load-use.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    hazard_stall_unit_if.slave bus
);

    state_e state_q, state_d;
    logic   pending_flush_q, pending_flush_d;
    logic   load_use;
    logic   stall_inc, flush_inc;

    assign load_use = detect_load_use(bus.ctrl_mem_read_id_ex, bus.mux_reg_dst_out_id_ex,
                                      bus.register_RS, bus.register_RT, bus.ctrl_uses_rt);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d               = state_q;
        pending_flush_d       = pending_flush_q;
        bus.ctrl_pc_write     = 1'b1;
        bus.ctrl_if_id_write  = 1'b1;
        bus.ctrl_id_ex_bubble = 1'b0;
        bus.ctrl_if_id_flush  = 1'b0;
        bus.ctrl_pipe_freeze  = 1'b0;
        stall_inc             = 1'b0;
        flush_inc             = 1'b0;

        if (reset) begin
            bus.ctrl_pc_write     = 1'b0;
            bus.ctrl_if_id_write  = 1'b0;
            bus.ctrl_id_ex_bubble = 1'b1;
            state_d               = ST_RUN;
            pending_flush_d       = 1'b0;
        end else if (bus.mem_busy) begin
            bus.ctrl_pc_write    = 1'b0;
            bus.ctrl_if_id_write = 1'b0;
            bus.ctrl_pipe_freeze = 1'b1;
            state_d              = ST_FREEZE;
            // A branch resolved while frozen must still redirect once memory releases.
            if (state_q == ST_FREEZE && bus.branch_taken_ex) begin
                pending_flush_d = 1'b1;
            end
        end else begin
            state_d = ST_RUN;
            if (pending_flush_q || bus.branch_taken_ex) begin
                bus.ctrl_if_id_flush  = 1'b1;
                bus.ctrl_id_ex_bubble = 1'b1;
                pending_flush_d       = 1'b0;
                flush_inc             = 1'b1;
            end else if (load_use) begin
                bus.ctrl_pc_write     = 1'b0;
                bus.ctrl_if_id_write  = 1'b0;
                bus.ctrl_id_ex_bubble = 1'b1;
                stall_inc             = 1'b1;
            end
        end
    end

    sat_counter16 u_stall_cnt (
        .clock    (clock),
        .clear_i  (reset),
        .enable_i (stall_inc),
        .count_o  (bus.stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clock    (clock),
        .clear_i  (reset),
        .enable_i (flush_inc),
        .count_o  (bus.flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: the driver queues the expected
// per-cycle response, a negedge monitor pops and compares it.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    logic clock;
    logic reset;

    hazard_stall_unit_if bus();

    hazard_stall_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected word: {pc_write, if_id_write, bubble, flush, freeze, stall_count, flush_count}
    logic [36:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge clock) begin
        logic [36:0] exp_w;
        logic [36:0] act_w;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_w = {bus.ctrl_pc_write, bus.ctrl_if_id_write, bus.ctrl_id_ex_bubble,
                     bus.ctrl_if_id_flush, bus.ctrl_pipe_freeze, bus.stall_count, bus.flush_count};
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL %s: got ctl=%b stall=%h flush=%h, want ctl=%b stall=%h flush=%h",
                         nm, act_w[36:32], act_w[31:16], act_w[15:0],
                         exp_w[36:32], exp_w[31:16], exp_w[15:0]);
            end
        end
    end

    task automatic set_inputs(input logic rst, input logic busy, input logic br, input logic mr,
                              input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urt);
        reset                     = rst;
        bus.mem_busy              = busy;
        bus.branch_taken_ex       = br;
        bus.ctrl_mem_read_id_ex   = mr;
        bus.mux_reg_dst_out_id_ex = dst;
        bus.register_RS           = rs;
        bus.register_RT           = rt;
        bus.ctrl_uses_rt          = urt;
    endtask

    // One checked cycle: apply inputs just after an edge, queue the expectation, advance.
    task automatic cyc(input string name, input logic rst, input logic busy, input logic br,
                       input logic mr, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] ctl,
                       input logic [15:0] sc, input logic [15:0] fc);
        set_inputs(rst, busy, br, mr, dst, rs, rt, urt);
        exp_q.push_back({ctl, sc, fc});
        name_q.push_back(name);
        @(posedge clock);
        #1;
    endtask

    localparam logic [4:0] RUN_OK = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00100;
    localparam logic [4:0] FLUSH  = 5'b11110;
    localparam logic [4:0] FROZEN = 5'b00001;
    localparam logic [4:0] IN_RST = 5'b00100;

    initial begin
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clock);
        #1;
        cyc("reset_hold",     1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IN_RST, 16'd0, 16'd0);
        cyc("idle",           0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd0, 16'd0);

        cyc("lw_rs_stall",    0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'd0, 16'd0);
        cyc("after_lw_rs",    0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, RUN_OK, 16'd1, 16'd0);
        cyc("lw_rt_stall",    0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1, STALL,  16'd1, 16'd0);
        cyc("rt_not_used",    0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, RUN_OK, 16'd2, 16'd0);
        cyc("dst_zero",       0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd2, 16'd0);

        cyc("br_over_lu",     0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, FLUSH,  16'd2, 16'd0);
        cyc("after_br",       0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd2, 16'd1);

        cyc("freeze_c1",      0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, FROZEN, 16'd2, 16'd1);
        cyc("freeze_c2_br",   0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, FROZEN, 16'd2, 16'd1);
        cyc("freeze_c3",      0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, FROZEN, 16'd2, 16'd1);
        cyc("release_flush",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, FLUSH,  16'd2, 16'd1);
        cyc("pending_clear",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd2, 16'd2);

        cyc("freeze_over_lu", 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0, FROZEN, 16'd2, 16'd2);
        cyc("release_lu",     0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'd2, 16'd2);
        cyc("after_rel_lu",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd3, 16'd2);

        cyc("held_lu_1",      0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'd3, 16'd2);
        cyc("held_lu_2",      0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'd4, 16'd2);
        cyc("held_lu_3",      0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'd5, 16'd2);
        cyc("after_held",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd6, 16'd2);

        cyc("rst_frz_c1",     0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, FROZEN, 16'd6, 16'd2);
        cyc("rst_frz_c2_br",  0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, FROZEN, 16'd6, 16'd2);
        cyc("rst_in_freeze",  1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, IN_RST, 16'd6, 16'd2);
        cyc("post_rst_run",   0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd0, 16'd0);
        cyc("post_rst_idle",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'd0, 16'd0);

        // Drive the stall counter up to 16'hFFFE with a long held load-use.
        set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        repeat (65534) @(posedge clock);
        #1;
        cyc("sat_stall_1",    0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'hFFFE, 16'd0);
        cyc("sat_stall_2",    0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'hFFFF, 16'd0);
        cyc("sat_stall_3",    0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL,  16'hFFFF, 16'd0);
        cyc("sat_hold",       0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, RUN_OK, 16'hFFFF, 16'd0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous active-high reset
- ctrl_mem_read_id_ex  in  1  instruction in EX is a load
- mux_reg_dst_out_id_ex  in  5  destination register of the instruction in EX
- register_RS  in  5  IF/ID rs [25:21]
- register_RT  in  5  IF/ID rt [20:16]
- ctrl_uses_rt  in  1  ID instruction reads rt as a source
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready, pipeline must freeze
- ctrl_pc_write  out  1  PC load enable
- ctrl_if_id_write  out  1  IF/ID register load enable
- ctrl_id_ex_bubble  out  1  zero the ID/EX control fields
- ctrl_if_id_flush  out  1  clear IF/ID to NOP
- ctrl_pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- stall_count  out  16  saturating count of load-use stall cycles
- flush_count  out  16  saturating count of flushes applied

Function
REQ-003 SHALL define load_use = ctrl_mem_read_id_ex & (mux_reg_dst_out_id_ex != 0) & ((mux_reg_dst_out_id_ex == register_RS) | (ctrl_uses_rt & mux_reg_dst_out_id_ex == register_RT)).
REQ-004 SHALL have the FSM states RUN and FREEZE, plus a 1-bit pending_flush register.
REQ-005 In RUN with mem_busy=0, branch_taken_ex=0 and load_use=0: pc_write=1, if_id_write=1, bubble=0, flush=0, freeze=0.
REQ-006 In RUN with load_use=1 and branch_taken_ex=0, the same cycle (combinational): pc_write=0, if_id_write=0, bubble=1; stall_count increments at the next edge.
REQ-007 In RUN with branch_taken_ex=1: pc_write=1, if_id_write=1, flush=1, bubble=1; load_use is ignored; flush_count increments.
REQ-008 mem_busy=1 in any state: pc_write=0, if_id_write=0, freeze=1, bubble=0, flush=0; next state FREEZE.
REQ-009 In FREEZE, branch_taken_ex=1 SHALL set pending_flush; flush outputs stay 0 while mem_busy=1.
REQ-010 In FREEZE with mem_busy=0 (release cycle): freeze=0; if pending_flush or branch_taken_ex, act as REQ-007 and clear pending_flush; else evaluate load_use as in RUN; next state RUN.
REQ-011 Priority SHALL be reset > mem_busy > flush (pending or live) > load_use.
REQ-012 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-013 Each stall or flush cycle SHALL increment its counter by exactly 1 per cycle.
REQ-014 A load_use held across N consecutive cycles SHALL produce N stall cycles; normally N=1, because the bubble clears ctrl_mem_read_id_ex.

Reset
REQ-015 While reset=1: pc_write=0, if_id_write=0, bubble=1, flush=0, freeze=0.
REQ-016 At the first edge with reset=1: state=RUN, pending_flush=0, stall_count=0, flush_count=0.
REQ-017 Reset asserted during FREEZE SHALL discard pending_flush.

Structure
REQ-018 A shared pipeline package SHALL hold the FSM state encoding, the register-address width (5), the counter width (16) and the saturation value.
REQ-019 SHALL instantiate the sub-module sat_counter16 (enable, synchronous clear, saturate) twice, once per counter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- lw $t0 in EX (mem_read=1, dst=8), ID rs=8 -> one cycle pc_write=0, if_id_write=0, bubble=1; stall_count=1.
- mem_read=1, dst=0, rs=0 -> no stall; all enables 1.
- Same cycle load_use=1 and branch_taken_ex=1 -> flush=1, bubble=1, pc_write=1; stall_count unchanged, flush_count=1.
- mem_busy high 3 cycles, branch_taken_ex pulsed during cycle 2 -> freeze=1 for 3 cycles, flush=0 during freeze, flush=1 on the release cycle, pending_flush cleared.
- Preload the stall counter at 16'hFFFE, apply 3 load-use stalls -> stall_count holds at 16'hFFFF.
- reset asserted mid-FREEZE with pending_flush=1 -> next cycle state RUN, no flush after reset release, counters 0.
